// File: rtl/data_memory_arbiter_if.sv
// Requester-side access port of the data memory arbiter.
// The requester drives the access fields; the arbiter returns the ack and the read data.
interface data_memory_arbiter_if #(
    parameter int unsigned ADDR_W = 8,
    parameter int unsigned DATA_W = 8
);
    logic              req;
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic              lock;
    logic              ack;
    logic [DATA_W-1:0] rdata;
    logic              rvalid;

    modport master (
        output req, we, addr, wdata, lock,
        input  ack, rdata, rvalid
    );

    modport slave (
        input  req, we, addr, wdata, lock,
        output ack, rdata, rvalid
    );
endinterface

// File: rtl/data_memory_arbiter.sv
// Round-robin arbiter sharing one single-port data memory between port A (load/store)
// and port B (loader/debug), with bounded lock bursts and registered read return.
module data_memory_arbiter #(
    parameter int unsigned ADDR_W   = 8,
    parameter int unsigned DATA_W   = 8,
    parameter int unsigned MAX_LOCK = 4
) (
    input  logic               clk,
    input  logic               reset,
    data_memory_arbiter_if.slave a,
    data_memory_arbiter_if.slave b,
    output logic               mem_write_enable,
    output logic [ADDR_W-1:0]  mem_address,
    output logic [DATA_W-1:0]  mem_data_in,
    input  logic [DATA_W-1:0]  mem_data_out
);
    localparam int unsigned     CNT_W     = 4;
    localparam logic [CNT_W-1:0] LOCK_LAST = CNT_W'(MAX_LOCK - 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GRANT_A = 2'd1,
        GRANT_B = 2'd2
    } state_t;

    state_t           state;
    logic             last_b;
    logic [CNT_W-1:0] lock_cnt;
    logic             grant_a;
    logic             grant_b;
    logic             stay_a;
    logic             stay_b;

    // A grant is only live outside reset, so reset suppresses the access in flight.
    assign grant_a = (state == GRANT_A) && !reset;
    assign grant_b = (state == GRANT_B) && !reset;
    assign a.ack   = grant_a;
    assign b.ack   = grant_b;

    // Burst continues unless the competitor is waiting and the lock budget is spent.
    assign stay_a = a.lock && a.req && !(b.req && (lock_cnt == LOCK_LAST));
    assign stay_b = b.lock && b.req && !(a.req && (lock_cnt == LOCK_LAST));

    always_comb begin
        mem_write_enable = 1'b0;
        mem_address      = '0;
        mem_data_in      = '0;
        if (grant_a) begin
            mem_write_enable = a.we;
            mem_address      = a.addr;
            mem_data_in      = a.wdata;
        end else if (grant_b) begin
            mem_write_enable = b.we;
            mem_address      = b.addr;
            mem_data_in      = b.wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            last_b   <= 1'b1;
            lock_cnt <= '0;
            a.rdata  <= '0;
            b.rdata  <= '0;
            a.rvalid <= 1'b0;
            b.rvalid <= 1'b0;
        end else begin
            a.rvalid <= 1'b0;
            b.rvalid <= 1'b0;
            case (state)
                IDLE: begin
                    lock_cnt <= '0;
                    if (a.req && (!b.req || last_b)) begin
                        state <= GRANT_A;
                    end else if (b.req) begin
                        state <= GRANT_B;
                    end
                end
                GRANT_A: begin
                    last_b <= 1'b0;
                    if (!a.we) begin
                        a.rdata  <= mem_data_out;
                        a.rvalid <= 1'b1;
                    end
                    if (stay_a) begin
                        lock_cnt <= b.req ? lock_cnt + CNT_W'(1) : '0;
                    end else if (b.req) begin
                        state    <= GRANT_B;
                        lock_cnt <= '0;
                    end else begin
                        state    <= IDLE;
                        lock_cnt <= '0;
                    end
                end
                GRANT_B: begin
                    last_b <= 1'b1;
                    if (!b.we) begin
                        b.rdata  <= mem_data_out;
                        b.rvalid <= 1'b1;
                    end
                    if (stay_b) begin
                        lock_cnt <= a.req ? lock_cnt + CNT_W'(1) : '0;
                    end else if (a.req) begin
                        state    <= GRANT_A;
                        lock_cnt <= '0;
                    end else begin
                        state    <= IDLE;
                        lock_cnt <= '0;
                    end
                end
                default: begin
                    state    <= IDLE;
                    lock_cnt <= '0;
                end
            endcase
        end
    end
endmodule
